// File: rtl/disp_pattern_scanner.sv
// rtl/disp_pattern_scanner.sv - row-scanning LCD test-pattern source with valid/ready output
// Optional overrun counter: define DISP_SCAN_OVERRUN_CNT_EN.
module disp_pattern_scanner #(
    parameter int ROWS = 10,
    parameter int COLS = 10,
    parameter int AW   = 4,
    parameter int FW   = 4
) (
    input  logic            clk_40M,
    input  logic            rst,
    input  logic            step,
    input  logic [1:0]      mode,
    input  logic            freeze,
    input  logic            ready,
`ifdef DISP_SCAN_OVERRUN_CNT_EN
    input  logic            overrun_clr,
    output logic [7:0]      overrun_cnt,
`endif
    output logic [AW-1:0]   addr,
    output logic [COLS-1:0] data_out,
    output logic            valid,
    output logic            frame_done
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
    localparam logic [FW-1:0] LAST_F   = FW'(COLS - 1);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [FW-1:0] f;
    logic [1:0]    mode_q;
    logic          pending;
    logic [1:0]    mode_use;

    // A new mode takes effect on the first row of a frame, including that row itself.
    assign mode_use = (ptr == '0) ? mode : mode_q;

    function automatic logic [COLS-1:0] pattern(input logic [1:0] m,
                                                input logic [AW-1:0] r,
                                                input logic [FW-1:0] fr);
        logic [COLS-1:0] p;
        int rf;
        int fi;
        int idx;
        int cs;
        p   = '0;
        rf  = 32'(r) + 32'(fr);
        fi  = 32'(fr);
        idx = rf % COLS;
        for (int c = 0; c < COLS; c++) begin
            cs = (c + rf) % COLS;
            case (m)
                2'd0:    p[c] = (c == idx);
                2'd1:    p[c] = ~cs[0];
                2'd2:    p[c] = 1'b1;
                default: p[c] = (c <= fi);
            endcase
        end
        return p;
    endfunction

    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr       <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            ptr        <= '0;
            f          <= '0;
            mode_q     <= 2'd0;
            pending    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if ((step || pending) && !freeze) begin
                        state   <= LOAD;
                        pending <= 1'b0;
                    end else if (step) begin
                        pending <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ptr == '0)
                        mode_q <= mode;
                    addr     <= ptr;
                    data_out <= pattern(mode_use, ptr, f);
                    valid    <= 1'b1;
                    state    <= HOLD;
                    if (step)
                        pending <= 1'b1;
                end
                HOLD: begin
                    if (step)
                        pending <= 1'b1;
                    if (ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                        if (ptr == LAST_ROW) begin
                            ptr        <= '0;
                            f          <= (f == LAST_F) ? '0 : f + FW'(1);
                            frame_done <= 1'b1;
                        end else begin
                            ptr <= ptr + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DISP_SCAN_OVERRUN_CNT_EN
    logic dropped;
    assign dropped = step & pending;

    always_ff @(posedge clk_40M or negedge rst) begin
        if (!rst)
            overrun_cnt <= 8'd0;
        else if (overrun_clr)
            overrun_cnt <= dropped ? 8'd1 : 8'd0;
        else if (dropped && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_disp_pattern_scanner.sv
// tb/tb_disp_pattern_scanner.sv - directed self-checking bench for disp_pattern_scanner
`timescale 1ns/1ps
module tb_disp_pattern_scanner;

    logic       clk_40M = 1'b0;
    logic       rst = 1'b0;
    logic       step = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       freeze = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] addr;
    logic [9:0] data_out;
    logic       valid;
    logic       frame_done;
`ifdef DISP_SCAN_OVERRUN_CNT_EN
    logic       overrun_clr = 1'b0;
    logic [7:0] overrun_cnt;
`endif

    int checks = 0;
    int failures = 0;

    disp_pattern_scanner #(.ROWS(10), .COLS(10), .AW(4), .FW(4)) dut (
        .clk_40M    (clk_40M),
        .rst        (rst),
        .step       (step),
        .mode       (mode),
        .freeze     (freeze),
        .ready      (ready),
`ifdef DISP_SCAN_OVERRUN_CNT_EN
        .overrun_clr(overrun_clr),
        .overrun_cnt(overrun_cnt),
`endif
        .addr       (addr),
        .data_out   (data_out),
        .valid      (valid),
        .frame_done (frame_done)
    );

    always #5 clk_40M = ~clk_40M;

    task automatic tick();
        @(posedge clk_40M);
        #1;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0; step = 1'b0; freeze = 1'b0; ready = 1'b0; mode = 2'd0;
`ifdef DISP_SCAN_OVERRUN_CNT_EN
        overrun_clr = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (valid !== 1'b0 || addr !== 4'd0 || data_out !== 10'h000 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state valid=%b addr=%0d data=%h fd=%b expected 0/0/000/0", valid, addr, data_out, frame_done);
        end
`ifdef DISP_SCAN_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_overrun got=%0d expected=0", overrun_cnt);
        end
`endif
        rst = 1'b1;
        tick();
    endtask

    task automatic test_walking();
        logic [9:0] exp_d;
        logic [3:0] exp_a;
        mode = 2'd0;
        ready = 1'b1;
        for (int r = 0; r < 11; r++) begin
            exp_d = (r < 10) ? 10'(1 << r) : 10'h002;
            exp_a = (r < 10) ? 4'(r) : 4'd0;
            pulse_step();
            checks++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL walk_latency r=%0d valid=%b expected=0 one cycle after step", r, valid);
            end
            tick();
            checks++;
            if (valid !== 1'b1 || addr !== exp_a || data_out !== exp_d) begin
                failures++;
                $display("FAIL walk_row r=%0d valid=%b addr=%0d data=%h expected 1/%0d/%h", r, valid, addr, data_out, exp_a, exp_d);
            end
            tick();
            checks++;
            if (valid !== 1'b0 || frame_done !== (r == 9)) begin
                failures++;
                $display("FAIL walk_accept r=%0d valid=%b fd=%b expected 0/%b", r, valid, frame_done, (r == 9));
            end
            tick();
            checks++;
            if (frame_done !== 1'b0) begin
                failures++;
                $display("FAIL walk_fd_pulse r=%0d fd=%b expected=0", r, frame_done);
            end
            repeat (46) tick();
        end
    endtask

    task automatic test_checker_stall();
        logic bad;
        apply_reset();
        mode = 2'd1;
        ready = 1'b0;
        pulse_step();
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd0 || data_out !== 10'h155) begin
            failures++;
            $display("FAIL checker_row0 valid=%b addr=%0d data=%h expected 1/0/155", valid, addr, data_out);
        end
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (valid !== 1'b1 || addr !== 4'd0 || data_out !== 10'h155) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL stall_stable unstable=%b expected=0", bad);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || data_out !== 10'h155) begin
            failures++;
            $display("FAIL stall_release valid=%b data=%h expected 0/155", valid, data_out);
        end
        pulse_step();
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd1 || data_out !== 10'h2AA) begin
            failures++;
            $display("FAIL checker_row1 valid=%b addr=%0d data=%h expected 1/1/2aa", valid, addr, data_out);
        end
        tick();
    endtask

    task automatic test_freeze();
        logic seen;
        freeze = 1'b1;
        pulse_step();
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL freeze_hold valid_seen=%b expected=0", seen);
        end
        freeze = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL freeze_release_early valid=%b expected=0", valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd2 || data_out !== 10'h155) begin
            failures++;
            $display("FAIL freeze_release valid=%b addr=%0d data=%h expected 1/2/155", valid, addr, data_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic seen;
        ready = 1'b0;
        pulse_step();
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd3 || data_out !== 10'h2AA) begin
            failures++;
            $display("FAIL b2b_row3 valid=%b addr=%0d data=%h expected 1/3/2aa", valid, addr, data_out);
        end
        repeat (3) begin
            pulse_step();
            tick();
        end
        checks++;
        if (valid !== 1'b1 || addr !== 4'd3) begin
            failures++;
            $display("FAIL b2b_hold valid=%b addr=%0d expected 1/3", valid, addr);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept valid=%b expected=0", valid);
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_load valid=%b expected=0", valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd4 || data_out !== 10'h155) begin
            failures++;
            $display("FAIL b2b_pending_row valid=%b addr=%0d data=%h expected 1/4/155", valid, addr, data_out);
        end
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL b2b_extra_row seen=%b expected=0", seen);
        end
`ifdef DISP_SCAN_OVERRUN_CNT_EN
        checks++;
        if (overrun_cnt !== 8'd2) begin
            failures++;
            $display("FAIL overrun_count got=%0d expected=2", overrun_cnt);
        end
`endif
    endtask

    task automatic test_accept_step();
        ready = 1'b0;
        pulse_step();
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd5) begin
            failures++;
            $display("FAIL accstep_row5 valid=%b addr=%0d expected 1/5", valid, addr);
        end
        ready = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL accstep_load valid=%b expected=0", valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd6 || data_out !== 10'h155) begin
            failures++;
            $display("FAIL accstep_row6 valid=%b addr=%0d data=%h expected 1/6/155", valid, addr, data_out);
        end
        tick();
    endtask

`ifdef DISP_SCAN_OVERRUN_CNT_EN
    task automatic test_overrun_clear();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++;
        if (overrun_cnt !== 8'd0) begin
            failures++;
            $display("FAIL overrun_clr got=%0d expected=0", overrun_cnt);
        end
        freeze = 1'b1;
        pulse_step();
        step = 1'b1;
        overrun_clr = 1'b1;
        tick();
        step = 1'b0;
        overrun_clr = 1'b0;
        checks++;
        if (overrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL overrun_clr_drop got=%0d expected=1", overrun_cnt);
        end
        freeze = 1'b0;
        repeat (4) tick();
    endtask
`endif

    task automatic test_mode_switch();
        apply_reset();
        mode = 2'd2;
        ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            if (r == 4) mode = 2'd3;
            pulse_step();
            tick();
            checks++;
            if (valid !== 1'b1 || addr !== 4'(r) || data_out !== 10'h3FF) begin
                failures++;
                $display("FAIL mode_allon r=%0d valid=%b addr=%0d data=%h expected 1/%0d/3ff", r, valid, addr, data_out, r);
            end
            tick();
            if (r == 9) begin
                checks++;
                if (frame_done !== 1'b1) begin
                    failures++;
                    $display("FAIL mode_frame_done fd=%b expected=1", frame_done);
                end
            end
            repeat (3) tick();
        end
        pulse_step();
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd0 || data_out !== 10'h003) begin
            failures++;
            $display("FAIL mode_bar_row0 valid=%b addr=%0d data=%h expected 1/0/003", valid, addr, data_out);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        ready = 1'b0;
        pulse_step();
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd1 || data_out !== 10'h003) begin
            failures++;
            $display("FAIL rsthold_row1 valid=%b addr=%0d data=%h expected 1/1/003", valid, addr, data_out);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || addr !== 4'd0 || data_out !== 10'h000) begin
            failures++;
            $display("FAIL rsthold_async valid=%b addr=%0d data=%h expected 0/0/000", valid, addr, data_out);
        end
        tick();
        rst = 1'b1;
        tick();
        ready = 1'b1;
        pulse_step();
        tick();
        checks++;
        if (valid !== 1'b1 || addr !== 4'd0 || data_out !== 10'h001) begin
            failures++;
            $display("FAIL rsthold_restart valid=%b addr=%0d data=%h expected 1/0/001", valid, addr, data_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_walking();
        test_checker_stall();
        test_freeze();
        test_back_to_back();
        test_accept_step();
`ifdef DISP_SCAN_OVERRUN_CNT_EN
        test_overrun_clear();
`endif
        test_mode_switch();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_pattern_scanner.md
Name: disp_pattern_scanner

Overview:
- Parametrised successor of the fake display-RAM data source: it steps a row address through ROWS rows and presents COLS-bit row data for LCD convert/display testing.
- Provides four selectable test patterns, a frame counter that animates the patterns, and a freeze control.
- Runs entirely on clk_40M. Row advance is requested by a one-cycle step strobe instead of a slow clock.
- Outputs go through a valid/ready handshake so the display converter can stall the scanner.

Parameters:
ROWS, 10, number of rows per frame (2..2^AW)
COLS, 10, row data width in bits / columns (2..32)
AW, 4, address width; 2^AW >= ROWS required
FW, 4, frame counter width; 2^FW >= COLS required

Ports:
clk_40M  in   1     system clock, all logic on its rising edge
rst      in   1     asynchronous, active-low reset
step     in   1     one-cycle strobe requesting the next row (e.g. 1 Hz tick)
mode     in   2     pattern select, sampled at frame start
freeze   in   1     1 = hold off presenting new rows; requests are kept pending
ready    in   1     consumer accepts the current row
addr     out  AW    row address of presented data
data_out out  COLS  row data
valid    out  1     addr/data_out valid
frame_done out 1    one-cycle pulse when the last row of a frame is accepted

Behaviour:
- Reset (rst=0, asynchronous) sets: addr=0, data_out=0, valid=0, frame_done=0, row pointer ptr=0, frame count f=0, latched mode mode_q=0, pending=0, state=IDLE.
- FSM states are IDLE, LOAD and HOLD.
- IDLE:
  - If (step or pending) and freeze=0, go to LOAD and clear pending.
  - If step and freeze=1, set pending and stay in IDLE.
- LOAD (one cycle):
  - If ptr==0, set mode_q<=mode; the new mode applies to this row.
  - Register addr<=ptr and data_out<=pattern(mode used, ptr, f), then set valid=1 and go to HOLD.
  - Latency: step in cycle n gives valid=1 in cycle n+2.
- HOLD:
  - addr and data_out stay stable while valid=1.
  - Freeze has no effect in HOLD.
  - When valid&ready: valid=0 in the next cycle and the state returns to IDLE.
  - If ptr<ROWS-1, ptr increments.
  - If ptr==ROWS-1: ptr=0, f=(f==COLS-1)?0:f+1, and frame_done=1 for exactly one cycle.
- Step in LOAD or HOLD sets pending. On return to IDLE with pending=1 and freeze=0, LOAD starts the very next cycle.
- Step while pending is already 1 is dropped (one request is held at most).
- addr and data_out keep their last values after valid drops.
- Patterns, for row r, frame f, column bit c (0=LSB), indices taken mod COLS:
  - mode 0, walking one: only bit (r+f) mod COLS is set. With f=0 and ROWS=COLS=10 this is a single set bit moving LSB to MSB, one row per step.
  - mode 1, checker: bit c = ~(c+r+f)[0]. The parity inverts every frame.
  - mode 2, all-on: all COLS bits = 1.
  - mode 3, bar: bit c = 1 iff c <= f.
- Arithmetic: r+f and c+r+f are computed in widths wide enough to avoid overflow, then reduced mod COLS without truncation error.
- Simultaneous events:
  - step in the same cycle as valid&ready acceptance sets pending.
  - Reset mid-HOLD drops valid immediately, asynchronously.

Optional Feature:
- Macro: DISP_SCAN_OVERRUN_CNT_EN.
- When defined:
  - Adds output overrun_cnt [7:0], reset to 0.
  - It increments on each dropped step (step while pending=1) and saturates at 255.
  - Adds input overrun_clr: a one-cycle pulse that zeroes the counter. If overrun_clr and a dropped step occur in the same cycle, the counter ends at 1.
- When undefined: no such ports exist, and dropped steps are silently discarded.

Test Plan:
- Reset, mode=0, ready=1, then 10 steps spaced 50 cycles apart.
  - Required: addr 0..9 with data_out 0x001,0x002,...,0x200.
  - valid is high 1 cycle each, 2 cycles after each step.
  - frame_done pulses after addr 9; the next frame starts with addr=0 and data 0x002 (f=1).
- mode=1, hold ready=0 for 20 cycles after valid.
  - Required: addr/data_out stable and valid=1 for the whole stall.
  - Row 0 of frame 0 data=0x155; row 1 data=0x2AA.
- freeze=1, then step: valid stays 0. Release freeze 30 cycles later.
  - Required: valid=1 two cycles after release.
- Three steps during HOLD with ready=0, then ready=1.
  - Required: exactly one further row is presented; with DISP_SCAN_OVERRUN_CNT_EN, overrun_cnt=2.
- mode changed from 2 to 3 at row 4.
  - Required: rows 4-9 still 0x3FF; the next frame uses the bar pattern, row 0 data=0x003 (f=1).
- rst asserted low mid-HOLD.
  - Required: valid, addr and data_out=0 immediately; the next step after release presents addr=0.
